inc_dec_counter_seq: RTL
========================

// Module: inc_dec_counter_seq
// PURPOSE
//   Registered up/down counter built on the team's 4-bit add/subtract datapath. Each applied
//   step computes count +/- step through an add/sub path: m=1 adds, m=0 subtracts via ~step+1.
//   A small FSM can also apply the step automatically for N consecutive cycles.
//   Sits after the combinational inc/dec stage as its registered, sequenced consumer.
// PARAMETERS
//   WIDTH  4  datapath width, in bits, of count, step and load_val
//   SAT    0  0 = wrap modulo 2^WIDTH; 1 = saturate at 0 / 2^WIDTH-1
// PORTS
//   clk       in   1      single clock; all state changes on the rising edge
//   rst_n     in   1      reset: asynchronous, active low
//   load      in   1      synchronous load of load_val; highest priority
//   load_val  in   WIDTH  value written to count on load
//   m         in   1      mode: 1 = increment by step, 0 = decrement by step
//   step      in   WIDTH  operand added to or subtracted from count
//   en        in   1      apply one step this cycle; acted on in IDLE only
//   start     in   1      begin a burst of n_ops steps; acted on in IDLE only
//   n_ops     in   WIDTH  burst length; sampled together with start
//   count     out  WIDTH  current counter value
//   wrap      out  1      last applied step overflowed (up) or underflowed (down)
//   busy      out  1      high while in RUN
//   done      out  1      one-cycle pulse when a burst completes
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     count=0, wrap=0, busy=0, done=0, FSM=IDLE, remaining=0.
//   Step arithmetic, on a WIDTH+1 bit sum:
//     up:   {c,r} = count + step;              overflow  = c
//     down: {c,r} = count + ~step + 1;         underflow = ~c
//     SAT=0: count <= r.
//     SAT=1: on overflow count <= 2^WIDTH-1; on underflow count <= 0.
//     wrap <= overflow|underflow on every applied step. wrap holds otherwise.
//     step=0 gives count unchanged and wrap=0 in both modes.
//   Priority each cycle: load > start > en.
//   FSM states:
//     IDLE:
//       load  -> count=load_val, wrap=0, stay IDLE.
//       start -> if n_ops==0: done=1 next cycle, stay IDLE, count unchanged.
//                else: remaining=n_ops, go to RUN, busy=1 from the next cycle.
//       en (and no start) -> apply one step, stay IDLE.
//     RUN:
//       Apply one step every cycle with the live m/step values and decrement remaining.
//       On the cycle remaining reaches 0: go to IDLE; busy=0 and done=1 the following cycle.
//       start and en are ignored.
//       load aborts the burst: count=load_val, wrap=0, go to IDLE, no done pulse.
//   Latency: single step -> count visible 1 cycle after en.
//     Burst of N -> busy high for exactly N cycles; final count and done in cycle N+1 after start.
//   done is high for exactly one cycle; busy and done are never both high.
//   An async reset mid-burst returns all state to the reset values immediately.
// TESTING
//   1. Reset, then en with m=1, step=3 for 5 cycles -> count 3,6,9,12,15; wrap=0 throughout.
//   2. SAT=0: load 14, en m=1 step=3 -> count=1, wrap=1.
//      Then en m=0 step=2 -> count=15, wrap=1.
//      Then en m=0 step=1 -> count=14, wrap=0.
//   3. SAT=1: load 14, en m=1 step=3 -> count=15, wrap=1.
//      Then load 1, en m=0 step=4 -> count=0, wrap=1.
//   4. Load 2, start n_ops=4, m=1 step=2 -> busy 4 cycles, count 4,6,8,10; done pulses once;
//      en and start during busy have no effect.
//   5. Start n_ops=0 -> done pulse next cycle, busy never high, count unchanged.
//      Start n_ops=5 and load 7 on the 3rd busy cycle -> count=7, IDLE, no done.
//   6. Async rst_n low mid-burst, asynchronous to clk -> count=0, busy=0, done=0, wrap=0
//      immediately; normal operation resumes after release.

Source files
------------

// File: rtl/inc_dec_counter_seq.sv
// inc_dec_counter_seq
// Registered up/down counter on an add/subtract datapath. A step is applied
// either once (en) or automatically for a burst of n_ops cycles (start).
// Subtraction is done as count + ~step + 1, so the carry out of the
// WIDTH+1 bit sum is set when there is no borrow.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; load, start or en act here (priority load > start > en)
// RUN   | burst in progress; one step per cycle until remaining hits 0
module inc_dec_counter_seq #(
    parameter int WIDTH = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             m,
    input  logic [WIDTH-1:0] step,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] n_ops,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] remaining;

    logic [WIDTH:0]   sum;
    logic             step_wrap;
    logic [WIDTH-1:0] step_next;

    // Next count and wrap flag for one step in the current mode.
    always_comb begin
        sum       = '0;
        step_wrap = 1'b0;
        step_next = '0;
        if (m) begin
            sum       = {1'b0, count} + {1'b0, step};
            step_wrap = sum[WIDTH];
        end else begin
            sum       = {1'b0, count} + {1'b0, ~step} + {{WIDTH{1'b0}}, 1'b1};
            step_wrap = ~sum[WIDTH];
        end
        if ((SAT != 0) && step_wrap) begin
            step_next = m ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end else begin
            step_next = sum[WIDTH-1:0];
        end
    end

    // Sequencing FSM; count, wrap, busy and done are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            count     <= '0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Load also aborts a running burst without a done pulse.
                count     <= load_val;
                wrap      <= 1'b0;
                state     <= IDLE;
                busy      <= 1'b0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (n_ops == '0) begin
                                done <= 1'b1;
                            end else begin
                                remaining <= n_ops;
                                state     <= RUN;
                                busy      <= 1'b1;
                            end
                        end else if (en) begin
                            count <= step_next;
                            wrap  <= step_wrap;
                        end
                    end
                    RUN: begin
                        count     <= step_next;
                        wrap      <= step_wrap;
                        remaining <= remaining - 1'b1;
                        if (remaining == WIDTH'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
